reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-read-port register file, the next generation of the 32x32 two-read/one-write CPU register file. It generalises data width, depth and read-port count, and clears every entry on asynchronous reset. It adds a sequenced bulk-clear engine (one entry per cycle, with busy/done handshake) and optional write-to-read bypass. It sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_WIDTH, 32, width of each register in bits
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
NUM_RD, 2, number of independent combinational read ports (1..8)
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes discarded, reads return 0); 0 = entry 0 is an ordinary register

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wen  input  1  write enable
waddr  input  ADDR_WIDTH  write address
wdata  input  DATA_WIDTH  write data
raddr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NUM_RD*DATA_WIDTH  packed read data; port i = bits [i*DATA_WIDTH +: DATA_WIDTH]
clr_req  input  1  request bulk clear of all entries
clr_busy  output  1  high while clear engine is running
clr_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset: rst asserted at any time (including mid-clear) asynchronously zeroes all DEPTH entries and forces FSM to IDLE, clr_busy=0, clr_done=0, clear counter=0. Release is synchronous to the next clk edge as usual.
- Write: on posedge clk, if wen && !clr_busy, entry[waddr] <= wdata. If ZERO_REG=1 and waddr==0, the write is discarded. Write latency 1 cycle.
- Read: fully combinational. rdata[i] = entry[raddr[i]]. Returns 0 when ZERO_REG=1 and raddr[i]==0. Any number of ports may address the same entry.
- Clear FSM states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, counter <= 0. clr_req is sampled only in IDLE.
  - CLEAR: clr_busy=1. Each cycle entry[counter] <= 0, counter++. When counter==DEPTH-1, that entry is cleared and the FSM moves to DONE. Occupancy is exactly DEPTH cycles.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle, then IDLE. clr_req high in DONE is ignored; a request still held in the following IDLE cycle starts a new clear.
- Writes with wen=1 while clr_busy=1 are dropped silently; no error flag.
- Reads during CLEAR return current contents: 0 for already-cleared entries, old data for the rest.
- Counter wrap: counter is ADDR_WIDTH bits wide and never wraps past DEPTH-1 within a clear.
- Simultaneous clr_req and wen in IDLE: the write completes on that edge; clearing starts the next cycle and later overwrites it.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: for each read port, if wen && !clr_busy && raddr[i]==waddr (and not the discarded zero-register case), rdata[i] = wdata in the same cycle (write-first forwarding).
- Undefined: rdata[i] shows the pre-write contents until the edge after the write (read-first).

Test Plan:
1. Assert rst mid-run after writing 0xDEADBEEF to r5 -> all rdata read 0 immediately, before any clk edge; clr_busy=0.
2. Write 0x12345678 to r7, then read r7 on ports 0 and 1 the next cycle -> both return 0x12345678. Write 0xFFFFFFFF to r0 -> r0 still reads 0 (ZERO_REG=1).
3. Same-cycle wen=1, waddr=3, wdata=0xA5A5A5A5, raddr0=3 -> 0xA5A5A5A5 with REG_FILE_BYPASS_EN, old value (0) without it.
4. Fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high for exactly 32 cycles, r0..r31 zeroed in order, clr_done single pulse on cycle 33; a wen to r9 during busy leaves r9=0.
5. Assert rst at cycle 10 of a clear -> clr_busy drops asynchronously, all entries 0, FSM IDLE; a new clr_req then takes the full 32 cycles.
6. NUM_RD=4, DATA_WIDTH=64, ADDR_WIDTH=4: write 0x0123456789ABCDEF to r15; all four ports read r15 -> all return 0x0123456789ABCDEF; clear takes 16 cycles.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with async clear-on-reset and a sequenced bulk-clear engine.
// Define REG_FILE_BYPASS_EN for write-first forwarding on the read ports.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    we;

    // Writes to the hardwired zero entry and writes during a clear are dropped.
    assign we = wen && !clr_busy && !(ZERO_REG && (waddr == '0));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_busy = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                clr_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_busy) begin
            mem_q[cnt_q] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem_q[ra];
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
`ifdef REG_FILE_BYPASS_EN
            if (we && (ra == waddr)) begin
                rd = wdata;
            end
`endif
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule
